alu_master: RTL and testbench
=============================

Name: alu_master

Overview:
- Synthesizable initiator for the simple_alu operation bus.
- Accepts a complete command (opcode, operand A, operand B) on a valid/ready front end.
- Serializes the command onto the opcode_valid/opcode/data bus, waits for done, and captures result/overflow.
- Returns them on a valid/ready response port.
- Sits between a host/sequencer and simple_alu, replacing the behavioural stimulus driver in system-level benches.

Parameters:
- DATA_WIDTH, 8, width of operands, data bus and result.
- TIMEOUT_CYCLES, 16, max cycles in WAIT_DONE before the operation is abandoned; legal range 1..(2**TO_WIDTH)-1.
- TO_WIDTH, 5, width of the timeout counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  host command valid.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  1  0 = add, 1 = subtract.
- cmd_a  input  DATA_WIDTH  operand A.
- cmd_b  input  DATA_WIDTH  operand B.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  host accepts response.
- rsp_result  output  DATA_WIDTH  captured ALU result.
- rsp_overflow  output  1  captured ALU overflow.
- rsp_timeout  output  1  done never arrived.
- opcode_valid  output  1  ALU bus: operand phase active.
- opcode  output  1  ALU bus: operation code.
- data  output  DATA_WIDTH  ALU bus: operand.
- done  input  1  ALU: result valid (single-cycle pulse).
- overflow  input  1  ALU: overflow, qualified by done.
- result  input  DATA_WIDTH  ALU: result, qualified by done.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE
  - cmd_ready = 1
  - rsp_valid, rsp_result, rsp_overflow, rsp_timeout = 0
  - opcode_valid = 0, opcode = 0, data = 0
  - timeout counter = 0
- FSM states: IDLE, SEND_A, SEND_B, WAIT_DONE, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch op/A/B, go to SEND_A, cmd_ready = 0 next cycle.
- SEND_A (bus cycle 1): opcode_valid = 1, opcode = latched op, data = A; next state SEND_B.
- SEND_B (bus cycle 2): opcode_valid = 1, opcode held, data = B; next state WAIT_DONE.
- WAIT_DONE:
  - opcode_valid = 0, opcode = 0, data = 0; counter increments each cycle.
  - done = 1: capture result/overflow into rsp_*, rsp_timeout = 0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without done: rsp_result = 0, rsp_overflow = 0, rsp_timeout = 1, go to RESP.
  - done in the same cycle the counter reaches its limit: done wins, no timeout.
- RESP:
  - rsp_valid = 1; rsp_* held stable while rsp_ready = 0.
  - On rsp_ready: rsp_valid = 0, counter cleared, go to IDLE with cmd_ready = 1.
  - Throughput is at most one command per 5 cycles plus ALU latency.
- Latency:
  - First opcode_valid = 1 appears one cycle after the accepting edge.
  - rsp_valid rises one cycle after the done edge.
- done while in IDLE, SEND_A, SEND_B or RESP is ignored; no state change, no capture.
- cmd_valid outside IDLE is ignored; cmd_ready is 0 there.
- Reset asserted mid-operation: every register returns to its reset value immediately. The bus is released (opcode_valid = 0) and any in-flight response is discarded.
- Widths: result is passed through unmodified; no arithmetic in this block; counter width is TO_WIDTH.

Decomposition:
- Shared package alu.pkg gains:
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1
  - FSM state enumeration localparams (3-bit encodings)
  - default DATA_WIDTH and TIMEOUT_CYCLES
- Single module; the timeout counter is inline.
- No sub-module is needed.

Test Plan:
- Add, no overflow: cmd op = 0, A = 8'h12, B = 8'h34; ALU model returns done with 8'h46, ovf 0 after 3 cycles. Required: bus shows 8'h12 then 8'h34 with opcode_valid high exactly 2 cycles; rsp_result = 8'h46, rsp_overflow = 0, rsp_timeout = 0.
- Add with overflow: op = 0, A = 8'hF0, B = 8'h20; model returns 8'h10, ovf 1. Required: rsp_result = 8'h10, rsp_overflow = 1.
- Timeout: the model never asserts done. Required: rsp_valid rises after exactly 16 WAIT_DONE cycles with rsp_timeout = 1 and rsp_result = 0. done injected on cycle 16 instead yields rsp_timeout = 0.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid. Required: rsp_* stable and cmd_ready = 0 throughout; a cmd_valid issued meanwhile is not accepted until the cycle after rsp_ready.
- Spurious done: pulse done during SEND_A with result 8'hAA. Required: ignored; the final response carries the real result 8'h46 from a later done.
- Reset mid-op: deassert reset_n during SEND_B. Required: opcode_valid, data, rsp_valid = 0 asynchronously and cmd_ready = 1 after release. A new sub with A = 8'h05, B = 8'h03 completes normally (model returns 8'h02).

Source files
------------

// File: rtl/alu_master_pkg.sv
// Shared definitions for the simple_alu bus initiator: opcodes, FSM encodings, defaults.
package alu_master_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    localparam int DEF_TO_WIDTH       = 5;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND_A    = 3'd1;
    localparam logic [2:0] ST_SEND_B    = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SEND_A    = ST_SEND_A,
        SEND_B    = ST_SEND_B,
        WAIT_DONE = ST_WAIT_DONE,
        RESP      = ST_RESP
    } state_t;

endpackage

// File: rtl/alu_master.sv
// Initiator for simple_alu: takes a host command, drives the two-beat operand bus,
// waits for done (with timeout) and returns the captured result on a valid/ready port.
module alu_master
    import alu_master_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_WIDTH       = DEF_TO_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
    output logic                  rsp_timeout,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  done,
    input  logic                  overflow,
    input  logic [DATA_WIDTH-1:0] result
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                r_state,        w_state;
    logic                  r_cmd_ready,    w_cmd_ready;
    logic                  r_rsp_valid,    w_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_result,   w_rsp_result;
    logic                  r_rsp_overflow, w_rsp_overflow;
    logic                  r_rsp_timeout,  w_rsp_timeout;
    logic                  r_opcode_valid, w_opcode_valid;
    logic                  r_opcode,       w_opcode;
    logic [DATA_WIDTH-1:0] r_data,         w_data;
    logic [DATA_WIDTH-1:0] r_b,            w_b;
    logic [TO_WIDTH-1:0]   r_cnt,          w_cnt;

    always_comb begin
        w_state        = r_state;
        w_cmd_ready    = r_cmd_ready;
        w_rsp_valid    = r_rsp_valid;
        w_rsp_result   = r_rsp_result;
        w_rsp_overflow = r_rsp_overflow;
        w_rsp_timeout  = r_rsp_timeout;
        w_opcode_valid = r_opcode_valid;
        w_opcode       = r_opcode;
        w_data         = r_data;
        w_b            = r_b;
        w_cnt          = r_cnt;
        case (r_state)
            IDLE: begin
                // Operand A goes straight onto the bus register; only B needs holding.
                if (cmd_valid && r_cmd_ready) begin
                    w_state        = SEND_A;
                    w_cmd_ready    = 1'b0;
                    w_opcode_valid = 1'b1;
                    w_opcode       = cmd_op;
                    w_data         = cmd_a;
                    w_b            = cmd_b;
                end
            end
            SEND_A: begin
                w_state = SEND_B;
                w_data  = r_b;
            end
            SEND_B: begin
                w_state        = WAIT_DONE;
                w_opcode_valid = 1'b0;
                w_opcode       = OP_ADD;
                w_data         = '0;
            end
            WAIT_DONE: begin
                w_cnt = r_cnt + TO_WIDTH'(1);
                // done on the final counted cycle still beats the timeout
                if (done) begin
                    w_state        = RESP;
                    w_rsp_valid    = 1'b1;
                    w_rsp_result   = result;
                    w_rsp_overflow = overflow;
                    w_rsp_timeout  = 1'b0;
                end else if (r_cnt == TO_LAST) begin
                    w_state        = RESP;
                    w_rsp_valid    = 1'b1;
                    w_rsp_result   = '0;
                    w_rsp_overflow = 1'b0;
                    w_rsp_timeout  = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                    w_cnt       = '0;
                    w_cmd_ready = 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cmd_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_opcode_valid <= 1'b0;
            r_opcode       <= OP_ADD;
            r_data         <= '0;
            r_b            <= '0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_state;
            r_cmd_ready    <= w_cmd_ready;
            r_rsp_valid    <= w_rsp_valid;
            r_rsp_result   <= w_rsp_result;
            r_rsp_overflow <= w_rsp_overflow;
            r_rsp_timeout  <= w_rsp_timeout;
            r_opcode_valid <= w_opcode_valid;
            r_opcode       <= w_opcode;
            r_data         <= w_data;
            r_b            <= w_b;
            r_cnt          <= w_cnt;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_timeout  = r_rsp_timeout;
    assign opcode_valid = r_opcode_valid;
    assign opcode       = r_opcode;
    assign data         = r_data;

endmodule

// File: tb/tb_alu_master.sv
// Scoreboard bench for alu_master: directed commands against a scripted ALU responder.
module tb_alu_master;
    import alu_master_pkg::*;

    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          ovf;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow;
    logic          rsp_timeout;
    logic          opcode_valid;
    logic          opcode;
    logic [DW-1:0] data;
    logic          done = 1'b0;
    logic          overflow = 1'b0;
    logic [DW-1:0] result = '0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;
    int   acc_cyc = 0;
    exp_t q[$];

    alu_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TO_WIDTH(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
        .done(done), .overflow(overflow), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the queue head;
    // it is popped on the handshake cycle.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("rsp_result", rsp_result, q[0].res);
                chk("rsp_overflow", rsp_overflow, q[0].ovf);
                chk("rsp_timeout", rsp_timeout, q[0].to);
                chk("cmd_ready_in_resp", cmd_ready, 1'b0);
                if (rsp_ready) begin
                    void'(q.pop_front());
                    hs_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic issue(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input exp_t e, input bit push);
        int n;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 100);
        chk("cmd_accept_bound", cmd_ready, 1'b1);
        acc_cyc = cyc + 1;
        if (push) q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // ALU responder: checks both operand beats and the bus release, then drives done
    // during WAIT_DONE cycle 'lat' (1-based), or never when give = 0.
    task automatic alu_model(input logic op, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                             input int lat, input bit give, input logic [DW-1:0] res,
                             input logic ovf, input bit spur);
        int n;
        n = 0;
        while (!opcode_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("bus_a_valid", opcode_valid, 1'b1);
        chk("bus_a_data", data, ea);
        chk("bus_a_op", opcode, op);
        if (spur) begin
            done = 1'b1; result = 8'hAA; overflow = 1'b1;
        end
        @(negedge clk);
        done = 1'b0; result = '0; overflow = 1'b0;
        chk("bus_b_valid", opcode_valid, 1'b1);
        chk("bus_b_data", data, eb);
        chk("bus_b_op", opcode, op);
        @(negedge clk);
        chk("bus_release", {opcode_valid, opcode, data}, 0);
        n = 1;
        while (!rsp_valid && n < 40) begin
            if (give && n == lat) begin
                done = 1'b1; result = res; overflow = ovf;
            end
            @(negedge clk);
            done = 1'b0; result = '0; overflow = 1'b0;
            n++;
        end
        chk("rsp_rise_cycle", n, give ? lat + 1 : TO + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_rsp", {rsp_valid, rsp_result, rsp_overflow, rsp_timeout}, 0);
        chk("reset_bus", {opcode_valid, opcode, data}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // add, no overflow
        fork
            issue(OP_ADD, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0}, 1'b1);
            alu_model(OP_ADD, 8'h12, 8'h34, 3, 1'b1, 8'h46, 1'b0, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // add with overflow
        fork
            issue(OP_ADD, 8'hF0, 8'h20, '{8'h10, 1'b1, 1'b0}, 1'b1);
            alu_model(OP_ADD, 8'hF0, 8'h20, 3, 1'b1, 8'h10, 1'b1, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // done never arrives
        fork
            issue(OP_SUB, 8'h40, 8'h01, '{8'h00, 1'b0, 1'b1}, 1'b1);
            alu_model(OP_SUB, 8'h40, 8'h01, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // done on the last counted cycle wins over timeout
        fork
            issue(OP_ADD, 8'h33, 8'h44, '{8'h77, 1'b0, 1'b0}, 1'b1);
            alu_model(OP_ADD, 8'h33, 8'h44, TO, 1'b1, 8'h77, 1'b0, 1'b0);
        join
        repeat (2) @(posedge clk);
        #1;

        // backpressure; the next command (with a spurious done in SEND_A) queues behind it
        rsp_ready = 1'b0;
        fork
            issue(OP_SUB, 8'h09, 8'h04, '{8'h05, 1'b0, 1'b0}, 1'b1);
            alu_model(OP_SUB, 8'h09, 8'h04, 2, 1'b1, 8'h05, 1'b0, 1'b0);
        join
        fork
            begin
                repeat (5) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                issue(OP_ADD, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0}, 1'b1);
            end
            alu_model(OP_ADD, 8'h12, 8'h34, 2, 1'b1, 8'h46, 1'b0, 1'b1);
        join
        chk("accept_after_handshake", acc_cyc, hs_cyc + 1);
        repeat (2) @(posedge clk);
        #1;

        // reset asserted during SEND_B
        issue(OP_ADD, 8'h11, 8'h22, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_send_b", {opcode_valid, data}, {1'b1, 8'h22});
        reset_n = 1'b0;
        #1;
        chk("async_reset_bus", {opcode_valid, opcode, data}, 0);
        chk("async_reset_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        fork
            issue(OP_SUB, 8'h05, 8'h03, '{8'h02, 1'b0, 1'b0}, 1'b1);
            alu_model(OP_SUB, 8'h05, 8'h03, 1, 1'b1, 8'h02, 1'b0, 1'b0);
        join
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
